imager_pixel_fifo: RTL and testbench

- Per-camera pixel packing and buffering stage for the imager subsystem.
- Sits between the N_CAM ADC controllers and the imager APB interface.
- Each channel packs PIX_W-bit ADC samples into 32-bit words and buffers them in a DEPTH-word FIFO.
- Reports empty / almost-full / full / sticky-overflow per channel and supports per-channel soft reset and end-of-frame flush of partial words.

---
 rtl/imager_pkg.sv | 22 ++
 rtl/imager_pixel_fifo_if.sv | 33 +++
 rtl/imager_chan_fifo.sv | 92 +++++++++
 rtl/imager_pixel_fifo.sv | 43 ++++
 tb/tb_imager_pixel_fifo.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imager_pkg.sv
// imager_pkg: shared widths, sizing helpers and legal-configuration check for the imager pixel FIFO
package imager_pkg;
    localparam int IMG_WORD_W = 32;
    localparam int MIN_CAM    = 1;
    localparam int MAX_CAM    = 4;
    localparam int MIN_DEPTH  = 4;
    localparam int MAX_DEPTH  = 4096;

    function automatic int ppw(input int pix_w);
        return IMG_WORD_W / pix_w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int n_cam, input int pix_w, input int depth, input int afull);
        return n_cam >= MIN_CAM && n_cam <= MAX_CAM && (pix_w == 8 || pix_w == 16) &&
               depth >= MIN_DEPTH && depth <= MAX_DEPTH && (depth & (depth - 1)) == 0 &&
               afull >= 0 && afull <= depth;
    endfunction
endpackage

// File: rtl/imager_pixel_fifo_if.sv
// imager_pixel_fifo_if: ADC-side pixel stream plus bus-side pop/status signals for all camera channels
interface imager_pixel_fifo_if
    import imager_pkg::*;
#(
    parameter int N_CAM = 2,
    parameter int PIX_W = 8,
    parameter int DEPTH = 512
);
    localparam int CW = cnt_w(DEPTH);
    logic [N_CAM-1:0]            chan_reset;
    logic [N_CAM-1:0]            pixel_valid;
    logic [N_CAM*PIX_W-1:0]      pixel_data;
    logic [N_CAM-1:0]            frame_done;
    logic [N_CAM-1:0]            fifo_read_enable;
    logic [N_CAM-1:0]            clear_overflow;
    logic [N_CAM*IMG_WORD_W-1:0] fifo_read_data;
    logic [N_CAM-1:0]            fifo_data_valid;
    logic [N_CAM-1:0]            fifo_empty;
    logic [N_CAM-1:0]            fifo_afull;
    logic [N_CAM-1:0]            fifo_full;
    logic [N_CAM-1:0]            fifo_overflow;
    logic [N_CAM*CW-1:0]         fifo_count;

    modport master (
        output chan_reset, pixel_valid, pixel_data, frame_done, fifo_read_enable, clear_overflow,
        input  fifo_read_data, fifo_data_valid, fifo_empty, fifo_afull, fifo_full, fifo_overflow, fifo_count
    );

    modport slave (
        input  chan_reset, pixel_valid, pixel_data, frame_done, fifo_read_enable, clear_overflow,
        output fifo_read_data, fifo_data_valid, fifo_empty, fifo_afull, fifo_full, fifo_overflow, fifo_count
    );
endinterface

// File: rtl/imager_chan_fifo.sv
// imager_chan_fifo: packs one camera's samples into 32-bit words and queues them in a single-clock FIFO
module imager_chan_fifo
    import imager_pkg::*;
#(
    parameter int  PIX_W     = 8,
    parameter int  DEPTH     = 512,
    parameter int  AFULL_LVL = DEPTH - 16,
    localparam int CW        = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_chan_reset,
    input  logic                  i_pixel_valid,
    input  logic [PIX_W-1:0]      i_pixel_data,
    input  logic                  i_frame_done,
    input  logic                  i_read_enable,
    input  logic                  i_clear_overflow,
    output logic [IMG_WORD_W-1:0] o_read_data,
    output logic                  o_data_valid,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic [CW-1:0]         o_count
);
    localparam int PPW = ppw(PIX_W);
    localparam int LW  = $clog2(PPW);
    localparam int AW  = $clog2(DEPTH);

    logic [LW-1:0]         r_lc;
    logic [IMG_WORD_W-1:0] r_pack;
    logic [IMG_WORD_W-1:0] r_rdata;
    logic [IMG_WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    logic                  r_ovf;
    logic [IMG_WORD_W-1:0] w_word;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_acc;
    logic                  w_drop;

    // Pack the incoming sample first, then decide whether the word leaves (full lanes or flush) and whether it fits
    always_comb begin
        w_word = i_pixel_valid ? (r_pack | (IMG_WORD_W'(i_pixel_data) << (PIX_W * int'(r_lc)))) : r_pack;
        w_push = (i_pixel_valid && r_lc == LW'(PPW - 1)) || (i_frame_done && (i_pixel_valid || r_lc != '0));
        w_pop  = i_read_enable && r_cnt != '0;
        w_acc  = w_push && (r_cnt != CW'(DEPTH) || w_pop);
        w_drop = w_push && !w_acc;
    end

    // Packer, pointers, occupancy and sticky overflow; a channel soft reset behaves like the global reset
    always_ff @(posedge clk) begin
        if (!reset || i_chan_reset) begin
            r_lc    <= '0;
            r_pack  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_lc    <= w_push ? '0 : (i_pixel_valid ? r_lc + 1'b1 : r_lc);
            r_pack  <= w_push ? '0 : w_word;
            r_wp    <= w_acc ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
            r_rdata <= w_pop ? r_mem[r_rp] : r_rdata;
            r_valid <= w_pop;
            r_cnt   <= r_cnt + CW'(w_acc) - CW'(w_pop);
            r_ovf   <= w_drop || (r_ovf && !i_clear_overflow);
        end
    end

    // Word storage; a push into a full FIFO with a same-cycle pop reuses the slot being read (read-first)
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wp] <= w_word;
    end

    // Status flags come straight from the registered occupancy
    always_comb begin
        o_read_data  = r_rdata;
        o_data_valid = r_valid;
        o_count      = r_cnt;
        o_overflow   = r_ovf;
        o_empty      = r_cnt == '0;
        o_afull      = r_cnt >= CW'(AFULL_LVL);
        o_full       = r_cnt == CW'(DEPTH);
    end
endmodule

// File: rtl/imager_pixel_fifo.sv
// imager_pixel_fifo: per-camera pixel packing FIFOs between the ADC controllers and the imager bus
module imager_pixel_fifo
    import imager_pkg::*;
#(
    parameter int N_CAM     = 2,
    parameter int PIX_W     = 8,
    parameter int DEPTH     = 512,
    parameter int AFULL_LVL = DEPTH - 16
) (
    input  logic                clk,
    input  logic                reset,
    imager_pixel_fifo_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);

    if (!cfg_ok(N_CAM, PIX_W, DEPTH, AFULL_LVL)) begin : g_bad_cfg
        $error("imager_pixel_fifo: unsupported N_CAM/PIX_W/DEPTH/AFULL_LVL combination");
    end

    for (genvar c = 0; c < N_CAM; c++) begin : g_chan
        imager_chan_fifo #(
            .PIX_W     (PIX_W),
            .DEPTH     (DEPTH),
            .AFULL_LVL (AFULL_LVL)
        ) u_chan (
            .clk              (clk),
            .reset            (reset),
            .i_chan_reset     (bus.chan_reset[c]),
            .i_pixel_valid    (bus.pixel_valid[c]),
            .i_pixel_data     (bus.pixel_data[c*PIX_W +: PIX_W]),
            .i_frame_done     (bus.frame_done[c]),
            .i_read_enable    (bus.fifo_read_enable[c]),
            .i_clear_overflow (bus.clear_overflow[c]),
            .o_read_data      (bus.fifo_read_data[c*IMG_WORD_W +: IMG_WORD_W]),
            .o_data_valid     (bus.fifo_data_valid[c]),
            .o_empty          (bus.fifo_empty[c]),
            .o_afull          (bus.fifo_afull[c]),
            .o_full           (bus.fifo_full[c]),
            .o_overflow       (bus.fifo_overflow[c]),
            .o_count          (bus.fifo_count[c*CW +: CW])
        );
    end
endmodule

// File: tb/tb_imager_pixel_fifo.sv
// tb_imager_pixel_fifo: table, hand-sequence and randomized checks of the pixel FIFO against a queue model
module tb_imager_pixel_fifo;
    import imager_pkg::*;

    localparam int D  = 16;
    localparam int AF = 12;
    localparam int CW = cnt_w(D);

    typedef struct {
        bit          pv;
        logic [7:0]  pd;
        bit          fd;
        bit          re;
        int          cnt;
        bit          vld;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] mq [2][$];
    logic [7:0]  mp [2][$];
    bit          movf [2];
    bit          mvld [2];
    logic [31:0] mrd [2];
    vec_t        tv [18];
    logic [31:0] got [$];

    always #5 clk = ~clk;

    imager_pixel_fifo_if #(.N_CAM(2), .PIX_W(8), .DEPTH(D)) ifa ();
    imager_pixel_fifo_if #(.N_CAM(1), .PIX_W(16), .DEPTH(D)) ifb ();

    imager_pixel_fifo #(.N_CAM(2), .PIX_W(8), .DEPTH(D), .AFULL_LVL(AF)) u_dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    imager_pixel_fifo #(.N_CAM(1), .PIX_W(16), .DEPTH(D), .AFULL_LVL(AF)) u_dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_a(input int c);
        return ifa.fifo_count[c*CW +: CW];
    endfunction

    function automatic logic [31:0] rd_a(input int c);
        return ifa.fifo_read_data[c*32 +: 32];
    endfunction

    task automatic idle();
        ifa.chan_reset = '0; ifa.pixel_valid = '0; ifa.pixel_data = '0;
        ifa.frame_done = '0; ifa.fifo_read_enable = '0; ifa.clear_overflow = '0;
        ifb.chan_reset = '0; ifb.pixel_valid = '0; ifb.pixel_data = '0;
        ifb.frame_done = '0; ifb.fifo_read_enable = '0; ifb.clear_overflow = '0;
    endtask

    task automatic set_a(input int c, input bit pv, input logic [7:0] pd, input bit fd,
                         input bit re, input bit co, input bit cr);
        ifa.pixel_valid[c] = pv;
        ifa.pixel_data[c*8 +: 8] = pd;
        ifa.frame_done[c] = fd;
        ifa.fifo_read_enable[c] = re;
        ifa.clear_overflow[c] = co;
        ifa.chan_reset[c] = cr;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mq[c].delete(); mp[c].delete();
            movf[c] = 0; mvld[c] = 0; mrd[c] = '0;
        end
    endtask

    // Reference: a word is the first four queued pixels (LSB first) or whatever is pending at frame end
    task automatic model(input int c);
        bit pop, push, drop;
        logic [31:0] w;
        if (ifa.chan_reset[c]) begin
            mq[c].delete(); mp[c].delete();
            movf[c] = 0; mvld[c] = 0; mrd[c] = '0;
            return;
        end
        pop = ifa.fifo_read_enable[c] && mq[c].size() > 0;
        if (ifa.pixel_valid[c]) mp[c].push_back(ifa.pixel_data[c*8 +: 8]);
        push = mp[c].size() == 4 || (ifa.frame_done[c] && mp[c].size() > 0);
        w = '0;
        if (push) begin
            for (int i = 0; i < mp[c].size(); i++) w = w | (32'(mp[c][i]) << (8 * i));
            mp[c].delete();
        end
        mvld[c] = pop;
        if (pop) mrd[c] = mq[c].pop_front();
        drop = push && mq[c].size() >= D;
        if (push && !drop) mq[c].push_back(w);
        movf[c] = drop ? 1'b1 : (ifa.clear_overflow[c] ? 1'b0 : movf[c]);
    endtask

    task automatic cyc();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_model(input string tag);
        logic [63:0] act, exp;
        int n;
        for (int c = 0; c < 2; c++) begin
            n = mq[c].size();
            exp = {22'd0, CW'(n), mvld[c], movf[c], n == 0, n >= AF, n == D, mrd[c]};
            act = {22'd0, cnt_a(c), ifa.fifo_data_valid[c], ifa.fifo_overflow[c],
                   ifa.fifo_empty[c], ifa.fifo_afull[c], ifa.fifo_full[c], rd_a(c)};
            chk($sformatf("%s ch%0d {cnt,vld,ovf,e,af,f,data}", tag, c), act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        chk("reset empty", 64'(ifa.fifo_empty), 64'h3);
        chk("reset count", 64'(ifa.fifo_count), 64'h0);
        chk("reset flags", {ifa.fifo_afull, ifa.fifo_full, ifa.fifo_overflow, ifa.fifo_data_valid}, 64'h0);
        chk("reset rdata", 64'(ifa.fifo_read_data), 64'h0);
        ifa.fifo_read_enable = 2'b11;
        cyc();
        chk("pop on empty valid", 64'(ifa.fifo_data_valid), 64'h0);
        chk("pop on empty count", 64'(ifa.fifo_count), 64'h0);

        tv[0]  = '{1, 8'h11, 0, 0, 0, 0, 32'h0};
        tv[1]  = '{1, 8'h22, 0, 0, 0, 0, 32'h0};
        tv[2]  = '{1, 8'h33, 0, 0, 0, 0, 32'h0};
        tv[3]  = '{1, 8'h44, 0, 0, 1, 0, 32'h0};
        tv[4]  = '{0, 8'h00, 0, 1, 0, 1, 32'h44332211};
        tv[5]  = '{0, 8'h00, 0, 0, 0, 0, 32'h44332211};
        tv[6]  = '{1, 8'hAA, 0, 0, 0, 0, 32'h44332211};
        tv[7]  = '{1, 8'hBB, 0, 0, 0, 0, 32'h44332211};
        tv[8]  = '{0, 8'h00, 1, 0, 1, 0, 32'h44332211};
        tv[9]  = '{0, 8'h00, 0, 1, 0, 1, 32'h0000BBAA};
        tv[10] = '{0, 8'h00, 1, 0, 0, 0, 32'h0000BBAA};
        tv[11] = '{1, 8'h01, 0, 0, 0, 0, 32'h0000BBAA};
        tv[12] = '{1, 8'h02, 0, 0, 0, 0, 32'h0000BBAA};
        tv[13] = '{1, 8'h03, 0, 0, 0, 0, 32'h0000BBAA};
        tv[14] = '{1, 8'h04, 1, 0, 1, 0, 32'h0000BBAA};
        tv[15] = '{0, 8'h00, 0, 0, 1, 0, 32'h0000BBAA};
        tv[16] = '{0, 8'h00, 0, 1, 0, 1, 32'h04030201};
        tv[17] = '{0, 8'h00, 0, 1, 0, 0, 32'h04030201};
        for (int i = 0; i < 18; i++) begin
            set_a(0, tv[i].pv, tv[i].pd, tv[i].fd, tv[i].re, 0, 0);
            cyc();
            chk($sformatf("vec%0d count", i), 64'(cnt_a(0)), 64'(tv[i].cnt));
            chk($sformatf("vec%0d valid", i), 64'(ifa.fifo_data_valid[0]), 64'(tv[i].vld));
            chk($sformatf("vec%0d rdata", i), 64'(rd_a(0)), 64'(tv[i].rd));
            chk($sformatf("vec%0d ch1 empty", i), 64'(ifa.fifo_empty[1]), 64'h1);
        end

        for (int i = 0; i < 16; i++) begin
            set_a(0, 1, 8'(i + 1), 1, 0, 0, 0);
            cyc();
            chk($sformatf("fill%0d count", i + 1), 64'(cnt_a(0)), 64'(i + 1));
            chk($sformatf("fill%0d afull", i + 1), 64'(ifa.fifo_afull[0]), 64'(i + 1 >= AF));
            chk($sformatf("fill%0d full", i + 1), 64'(ifa.fifo_full[0]), 64'(i + 1 == D));
        end
        set_a(0, 1, 8'hEE, 1, 0, 0, 0);
        cyc();
        chk("17th push count", 64'(cnt_a(0)), 64'd16);
        chk("17th push overflow", 64'(ifa.fifo_overflow[0]), 64'h1);
        repeat (3) cyc();
        chk("overflow sticky", 64'(ifa.fifo_overflow[0]), 64'h1);
        set_a(0, 1, 8'h77, 1, 1, 0, 0);
        cyc();
        chk("full push+pop count", 64'(cnt_a(0)), 64'd16);
        chk("full push+pop valid", 64'(ifa.fifo_data_valid[0]), 64'h1);
        chk("full push+pop data", 64'(rd_a(0)), 64'h1);
        chk("full push+pop overflow", 64'(ifa.fifo_overflow[0]), 64'h1);
        set_a(0, 1, 8'h99, 1, 0, 1, 0);
        cyc();
        chk("drop beats clear", 64'(ifa.fifo_overflow[0]), 64'h1);
        set_a(0, 0, 8'h00, 0, 0, 1, 0);
        cyc();
        chk("clear overflow", 64'(ifa.fifo_overflow[0]), 64'h0);

        for (int i = 0; i < 17; i++) begin
            set_a(1, 1, 8'(8'h80 + i), 1, 0, 0, 0);
            cyc();
        end
        chk("ch1 overflow before soft reset", 64'(ifa.fifo_overflow[1]), 64'h1);
        for (int i = 0; i < 13; i++) begin
            set_a(1, 0, 8'h00, 0, 1, 0, 0);
            cyc();
        end
        set_a(1, 1, 8'h55, 0, 0, 0, 0);
        cyc();
        set_a(1, 1, 8'h66, 0, 0, 0, 0);
        cyc();
        chk("ch1 count before soft reset", 64'(cnt_a(1)), 64'd3);
        set_a(1, 1, 8'h77, 1, 1, 0, 1);
        cyc();
        chk("soft reset ch1 count", 64'(cnt_a(1)), 64'h0);
        chk("soft reset ch1 empty", 64'(ifa.fifo_empty[1]), 64'h1);
        chk("soft reset ch1 overflow", 64'(ifa.fifo_overflow[1]), 64'h0);
        chk("soft reset ch1 valid", 64'(ifa.fifo_data_valid[1]), 64'h0);
        chk("soft reset ch0 count kept", 64'(cnt_a(0)), 64'd16);
        chk("soft reset ch0 full kept", 64'(ifa.fifo_full[0]), 64'h1);
        for (int i = 0; i < 4; i++) begin
            set_a(1, 1, 8'(8'hA1 + i), 0, 0, 0, 0);
            cyc();
            chk($sformatf("post reset lane%0d count", i), 64'(cnt_a(1)), 64'(i == 3));
        end
        set_a(1, 0, 8'h00, 0, 1, 0, 0);
        cyc();
        chk("post reset word", 64'(rd_a(1)), 64'hA4A3A2A1);
        set_a(0, 0, 8'h00, 0, 1, 0, 0);
        cyc();
        chk("ch0 head after soft reset", 64'(rd_a(0)), 64'h2);

        set_a(0, 0, 8'h00, 0, 0, 0, 1);
        cyc();
        for (int i = 0; i < 40; i++) begin
            set_a(0, 1, 8'(i + 1), 1, i >= 3, 0, 0);
            cyc();
            check_model("wrap");
            if (ifa.fifo_data_valid[0]) got.push_back(rd_a(0));
        end
        for (int k = 0; k < 32 && !ifa.fifo_empty[0]; k++) begin
            set_a(0, 0, 8'h00, 0, 1, 0, 0);
            cyc();
            if (ifa.fifo_data_valid[0]) got.push_back(rd_a(0));
        end
        chk("wrap words read", 64'(got.size()), 64'd40);
        for (int i = 0; i < got.size() && i < 40; i++) chk($sformatf("wrap word%0d", i), 64'(got[i]), 64'(i + 1));

        ifb.pixel_valid = 1'b1; ifb.pixel_data = 16'h1234;
        cyc();
        ifb.pixel_valid = 1'b1; ifb.pixel_data = 16'hABCD;
        cyc();
        chk("pix16 count", 64'(ifb.fifo_count), 64'd1);
        ifb.fifo_read_enable = 1'b1;
        cyc();
        chk("pix16 word", 64'(ifb.fifo_read_data), 64'hABCD1234);
        chk("pix16 valid", 64'(ifb.fifo_data_valid), 64'h1);
        ifb.pixel_valid = 1'b1; ifb.pixel_data = 16'h5555; ifb.frame_done = 1'b1;
        cyc();
        ifb.fifo_read_enable = 1'b1;
        cyc();
        chk("pix16 flush word", 64'(ifb.fifo_read_data), 64'h00005555);

        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 2; c++) begin
                set_a(c, 1'($urandom_range(1)), 8'($urandom), $urandom_range(7) == 0,
                      k < 1500 ? $urandom_range(9) == 0 : $urandom_range(2) == 0,
                      $urandom_range(15) == 0, $urandom_range(127) == 0);
            end
            cyc();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
